// File: rtl/button_press_classifier_pkg.sv
// button_press_classifier_pkg: FSM states, event encodings and timer sizing shared by button blocks
package button_press_classifier_pkg;
  typedef enum logic [2:0] {IDLE, PRESS1, HELD, GAP, PRESS2} state_t;
  typedef enum logic [2:0] {EV_NONE, EV_SHORT, EV_LONG, EV_DOUBLE, EV_REPEAT} event_t;
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/button_press_classifier_press_timer.sv
// press_timer: saturating gesture counter with load-to-1, clear and terminal-count compare
module press_timer #(
  parameter int W = 8
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Load,
  input  logic         i_Clear,
  input  logic         i_Inc,
  input  logic [W-1:0] i_Terminal,
  output logic         o_Hit
);
  logic [W-1:0] cnt;
  always_ff @(posedge i_Clk)
    if (i_Rst) cnt <= '0;
    else if (i_Load) cnt <= W'(1);
    else if (i_Clear) cnt <= '0;
    else if (i_Inc && cnt != '1) cnt <= cnt + 1'b1;
  assign o_Hit = cnt == i_Terminal;
endmodule

// File: rtl/button_press_classifier.sv
// button_press_classifier: short/long/double press events from a debounced level
// AUTO_REPEAT_EN adds periodic o_Repeat pulses while a long press is held.
module button_press_classifier
  import button_press_classifier_pkg::*;
#(
  parameter int LONG_PRESS_CYCLES = 25_000_000,
  parameter int DOUBLE_GAP_CYCLES = 7_500_000,
  parameter int REPEAT_CYCLES     = 5_000_000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Debounced,
  output logic o_Pressed,
  output logic o_Short_Press,
  output logic o_Long_Press,
  output logic o_Double_Press,
  output logic o_Repeat
);
  localparam int W = timer_width(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES, REPEAT_CYCLES);
  state_t state;
  logic r_Prev, rise, fall, load, clear, inc, hit;
  logic [W-1:0] terminal;
  assign rise = i_Debounced & ~r_Prev;
  assign fall = ~i_Debounced & r_Prev;
  always_comb begin
    terminal = state == GAP  ? W'(DOUBLE_GAP_CYCLES - 1) :
               state == HELD ? W'(REPEAT_CYCLES - 1) : W'(LONG_PRESS_CYCLES - 1);
    load     = (state == IDLE && rise) || (state == PRESS1 && fall);
    clear    = hit || (state == GAP && rise);
`ifdef AUTO_REPEAT_EN
    inc      = state == PRESS1 || state == GAP || state == HELD;
`else
    inc      = state == PRESS1 || state == GAP;
`endif
  end
  press_timer #(.W(W)) u_timer (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Load    (load),
    .i_Clear   (clear),
    .i_Inc     (inc),
    .i_Terminal(terminal),
    .o_Hit     (hit)
  );
  // r_Prev resets high so a button held through reset must be released before it counts
  always_ff @(posedge i_Clk)
    if (i_Rst) begin
      state          <= IDLE;
      r_Prev         <= 1'b1;
      o_Pressed      <= 1'b0;
      o_Short_Press  <= 1'b0;
      o_Long_Press   <= 1'b0;
      o_Double_Press <= 1'b0;
`ifdef AUTO_REPEAT_EN
      o_Repeat       <= 1'b0;
`endif
    end else begin
      r_Prev         <= i_Debounced;
      o_Pressed      <= i_Debounced;
      o_Short_Press  <= state == GAP && !rise && hit;
      o_Long_Press   <= state == PRESS1 && !fall && hit;
      o_Double_Press <= state == PRESS2 && fall;
`ifdef AUTO_REPEAT_EN
      o_Repeat       <= state == HELD && !fall && hit;
`endif
      case (state)
        IDLE:    if (rise) state <= PRESS1;
        PRESS1:  if (fall) state <= GAP; else if (hit) state <= HELD;
        HELD:    if (fall) state <= IDLE;
        GAP:     if (rise) state <= PRESS2; else if (hit) state <= IDLE;
        PRESS2:  if (fall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
`ifndef AUTO_REPEAT_EN
  assign o_Repeat = 1'b0;
`endif
endmodule
